// File: rtl/mem_bus_arbiter.sv
// Shares one 32-bit memory bus between instruction fetch and MEM-stage data accesses.
// Data accesses win ties; each returned word is held until its pipeline stage is released.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    output logic        bus_cyc_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;

    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_MEM, HOLD_IF, HOLD_MEM, DISCARD} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_reg, wait_next, wait_inc;
    logic          cyc_reg, cyc_next;
    logic          we_reg, we_next;
    logic [3:0]    sel_reg, sel_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [31:0]   if_hold_reg, if_hold_next;
    logic [31:0]   mem_hold_reg, mem_hold_next;
    logic          busy, timeout, done;
    logic [31:0]   rdata;
    logic          unused_stall_bits;

    assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

    // A timeout is handled exactly like an ack that returned zero.
    assign busy     = (state_reg == BUSY_IF) || (state_reg == BUSY_MEM) || (state_reg == DISCARD);
    assign timeout  = busy && !bus_ack_i && (wait_reg == CW'(TIMEOUT_CYC));
    assign done     = busy && (bus_ack_i || timeout);
    assign rdata    = bus_ack_i ? bus_data_i : 32'h0;
    assign wait_inc = (wait_reg == '1) ? wait_reg : wait_reg + CW'(1);

    always_comb begin
        state_next    = state_reg;
        wait_next     = wait_reg;
        cyc_next      = cyc_reg;
        we_next       = we_reg;
        sel_next      = sel_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        if_hold_next  = if_hold_reg;
        mem_hold_next = mem_hold_reg;
        case (state_reg)
            IDLE: begin
                if (!flush && mem_ce_i) begin
                    cyc_next   = 1'b1;
                    we_next    = mem_we_i;
                    sel_next   = mem_sel_i;
                    addr_next  = mem_addr_i;
                    wdata_next = mem_data_i;
                    wait_next  = '0;
                    state_next = BUSY_MEM;
                end else if (!flush && if_ce_i) begin
                    cyc_next   = 1'b1;
                    we_next    = 1'b0;
                    sel_next   = 4'hF;
                    addr_next  = if_addr_i;
                    wdata_next = 32'h0;
                    wait_next  = '0;
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (done) begin
                    cyc_next   = 1'b0;
                    we_next    = 1'b0;
                    sel_next   = 4'h0;
                    state_next = IDLE;
                    // A flush landing on the ack cycle drops the word just like DISCARD would.
                    if (!flush) begin
                        if (state_reg == BUSY_IF) begin
                            if_hold_next = rdata;
                            if (stall[1]) state_next = HOLD_IF;
                        end else begin
                            mem_hold_next = rdata;
                            if (stall[4]) state_next = HOLD_MEM;
                        end
                    end
                end else begin
                    wait_next = wait_inc;
                    if (flush) state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (done) begin
                    cyc_next   = 1'b0;
                    we_next    = 1'b0;
                    sel_next   = 4'h0;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_inc;
                end
            end
            HOLD_IF:  if (flush || !stall[1]) state_next = IDLE;
            HOLD_MEM: if (flush || !stall[4]) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_reg     <= '0;
            cyc_reg      <= 1'b0;
            we_reg       <= 1'b0;
            sel_reg      <= 4'h0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            if_hold_reg  <= 32'h0;
            mem_hold_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            wait_reg     <= wait_next;
            cyc_reg      <= cyc_next;
            we_reg       <= we_next;
            sel_reg      <= sel_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            if_hold_reg  <= if_hold_next;
            mem_hold_reg <= mem_hold_next;
        end
    end

    assign bus_cyc_o  = cyc_reg;
    assign bus_we_o   = we_reg;
    assign bus_sel_o  = sel_reg;
    assign bus_addr_o = addr_reg;
    assign bus_data_o = wdata_reg;
    assign bus_err_o  = !rst && timeout;

    assign if_data_o  = (state_reg == BUSY_IF && done) ? rdata :
                        (state_reg == HOLD_IF)         ? if_hold_reg : 32'h0;
    assign mem_data_o = (state_reg == BUSY_MEM && done) ? rdata :
                        (state_reg == HOLD_MEM)         ? mem_hold_reg : 32'h0;

    assign if_stallreq_o  = !rst && if_ce_i && (state_reg != HOLD_IF)
                            && !(state_reg == BUSY_IF && done);
    assign mem_stallreq_o = !rst && mem_ce_i && (state_reg != HOLD_MEM)
                            && !(state_reg == BUSY_MEM && done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level expectation queue.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_stallreq_o;
    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_stallreq_o(if_stallreq_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mem_stallreq_o(mem_stallreq_o),
        .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    task automatic cyc_t();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 6'h0; flush = 1'b0;
        if_ce_i = 1'b0; if_addr_i = 32'h0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
        mem_addr_i = 32'h0; mem_data_i = 32'h0;
        bus_data_i = 32'h0; bus_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; if_ce_i = 1'b1; mem_ce_i = 1'b1;
        cyc_t(); cyc_t(); #1;
        checks++; if (if_stallreq_o !== 1'b0) $display("FAIL reset_if_stallreq got=%b exp=0", if_stallreq_o); else passed++;
        checks++; if (mem_stallreq_o !== 1'b0) $display("FAIL reset_mem_stallreq got=%b exp=0", mem_stallreq_o); else passed++;
        if_ce_i = 1'b0; mem_ce_i = 1'b0; rst = 1'b0;
        cyc_t(); #1;
        checks++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'h0) $display("FAIL reset_bus_ctl got=%h exp=0", {bus_cyc_o, bus_we_o, bus_sel_o}); else passed++;
        checks++; if ({bus_addr_o, bus_data_o} !== 64'h0) $display("FAIL reset_bus_ad got=%h exp=0", {bus_addr_o, bus_data_o}); else passed++;
        checks++; if (bus_err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus_err_o); else passed++;
        checks++; if ({if_data_o, mem_data_o} !== 64'h0) $display("FAIL reset_data got=%h exp=0", {if_data_o, mem_data_o}); else passed++;
        $display("txn reset done");
    endtask

    task automatic test_fetch();
        cyc_t(); if_ce_i = 1'b1; if_addr_i = 32'h0000_0010; #1;
        checks++; if (if_stallreq_o !== 1'b1) $display("FAIL fetch_stall_c0 got=%b exp=1", if_stallreq_o); else passed++;
        cyc_t(); #1;
        checks++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'b10_1111) $display("FAIL fetch_bus_ctl got=%b exp=101111", {bus_cyc_o, bus_we_o, bus_sel_o}); else passed++;
        checks++; if (bus_addr_o !== 32'h10) $display("FAIL fetch_addr got=%h exp=00000010", bus_addr_o); else passed++;
        checks++; if (if_stallreq_o !== 1'b1) $display("FAIL fetch_stall_c1 got=%b exp=1", if_stallreq_o); else passed++;
        cyc_t(); bus_ack_i = 1'b1; bus_data_i = 32'h2401_0005; #1;
        checks++; if (if_data_o !== 32'h2401_0005) $display("FAIL fetch_data got=%h exp=24010005", if_data_o); else passed++;
        checks++; if (if_stallreq_o !== 1'b0) $display("FAIL fetch_stall_ack got=%b exp=0", if_stallreq_o); else passed++;
        cyc_t(); bus_ack_i = 1'b0; bus_data_i = 32'h0; if_ce_i = 1'b0; #1;
        checks++; if (bus_cyc_o !== 1'b0) $display("FAIL fetch_cyc_drop got=%b exp=0", bus_cyc_o); else passed++;
        $display("txn fetch addr=00000010 data=24010005");
    endtask

    task automatic test_contention();
        cyc_t();
        if_ce_i = 1'b1; if_addr_i = 32'h14;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h100; #1;
        checks++; if ({if_stallreq_o, mem_stallreq_o} !== 2'b11) $display("FAIL cont_stall_c0 got=%b exp=11", {if_stallreq_o, mem_stallreq_o}); else passed++;
        cyc_t(); #1;
        checks++; if (bus_cyc_o !== 1'b1 || bus_addr_o !== 32'h100) $display("FAIL cont_mem_first got=%b/%h exp=1/00000100", bus_cyc_o, bus_addr_o); else passed++;
        bus_ack_i = 1'b1; bus_data_i = 32'h0BAD_F00D; #1;
        checks++; if (mem_data_o !== 32'h0BAD_F00D) $display("FAIL cont_mem_data got=%h exp=0badf00d", mem_data_o); else passed++;
        checks++; if ({if_stallreq_o, mem_stallreq_o} !== 2'b10) $display("FAIL cont_stall_ack got=%b exp=10", {if_stallreq_o, mem_stallreq_o}); else passed++;
        cyc_t(); bus_ack_i = 1'b0; mem_ce_i = 1'b0; #1;
        checks++; if (bus_cyc_o !== 1'b0 || if_stallreq_o !== 1'b1) $display("FAIL cont_gap got=%b%b exp=01", bus_cyc_o, if_stallreq_o); else passed++;
        cyc_t(); #1;
        checks++; if (bus_cyc_o !== 1'b1 || bus_addr_o !== 32'h14 || if_stallreq_o !== 1'b1) $display("FAIL cont_if_start got=%b/%h/%b exp=1/00000014/1", bus_cyc_o, bus_addr_o, if_stallreq_o); else passed++;
        bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678; #1;
        checks++; if (if_data_o !== 32'h1234_5678 || if_stallreq_o !== 1'b0) $display("FAIL cont_if_ack got=%h/%b exp=12345678/0", if_data_o, if_stallreq_o); else passed++;
        cyc_t(); bus_ack_i = 1'b0; if_ce_i = 1'b0; #1;
        $display("txn contention mem=00000100 if=00000014");
    endtask

    task automatic test_hold();
        cyc_t(); mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h200;
        cyc_t(); stall = 6'b010000; bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF; #1;
        checks++; if (mem_data_o !== 32'hDEAD_BEEF) $display("FAIL hold_ack_data got=%h exp=deadbeef", mem_data_o); else passed++;
        for (int i = 0; i < 3; i++) begin
            cyc_t(); bus_ack_i = 1'b0; bus_data_i = $urandom; #1;
            checks++; if (mem_data_o !== 32'hDEAD_BEEF || mem_stallreq_o !== 1'b0 || bus_cyc_o !== 1'b0)
                $display("FAIL hold_cycle%0d got=%h/%b/%b exp=deadbeef/0/0", i, mem_data_o, mem_stallreq_o, bus_cyc_o); else passed++;
        end
        cyc_t(); stall = 6'h0; #1;
        checks++; if (mem_data_o !== 32'hDEAD_BEEF) $display("FAIL hold_release_data got=%h exp=deadbeef", mem_data_o); else passed++;
        cyc_t(); mem_ce_i = 1'b0; #1;
        checks++; if (mem_data_o !== 32'h0 || bus_cyc_o !== 1'b0) $display("FAIL hold_idle got=%h/%b exp=0/0", mem_data_o, bus_cyc_o); else passed++;
        $display("txn hold mem=00000200 data=deadbeef");
    endtask

    task automatic test_flush();
        cyc_t(); if_ce_i = 1'b1; if_addr_i = 32'h30;
        cyc_t(); flush = 1'b1; #1;
        checks++; if (bus_cyc_o !== 1'b1) $display("FAIL flush_cyc0 got=%b exp=1", bus_cyc_o); else passed++;
        cyc_t(); flush = 1'b0; if_addr_i = 32'h80; #1;
        checks++; if (bus_cyc_o !== 1'b1 || if_data_o !== 32'h0 || if_stallreq_o !== 1'b1) $display("FAIL flush_discard got=%b/%h/%b exp=1/0/1", bus_cyc_o, if_data_o, if_stallreq_o); else passed++;
        cyc_t(); bus_ack_i = 1'b1; bus_data_i = 32'h1111_2222; #1;
        checks++; if (bus_cyc_o !== 1'b1 || if_data_o !== 32'h0 || if_stallreq_o !== 1'b1) $display("FAIL flush_ack got=%b/%h/%b exp=1/0/1", bus_cyc_o, if_data_o, if_stallreq_o); else passed++;
        cyc_t(); bus_ack_i = 1'b0; #1;
        checks++; if (bus_cyc_o !== 1'b0) $display("FAIL flush_gap got=%b exp=0", bus_cyc_o); else passed++;
        cyc_t(); #1;
        checks++; if (bus_cyc_o !== 1'b1 || bus_addr_o !== 32'h80) $display("FAIL flush_refetch got=%b/%h exp=1/00000080", bus_cyc_o, bus_addr_o); else passed++;
        bus_ack_i = 1'b1; bus_data_i = 32'h3333_4444; #1;
        checks++; if (if_data_o !== 32'h3333_4444) $display("FAIL flush_newdata got=%h exp=33334444", if_data_o); else passed++;
        cyc_t(); bus_ack_i = 1'b0; if_ce_i = 1'b0; #1;
        $display("txn flush old=00000030 new=00000080");
    endtask

    task automatic test_timeout();
        int waits = 0;
        bit found = 0;
        cyc_t(); mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'h3;
        mem_addr_i = 32'h300; mem_data_i = 32'h0000_CAFE;
        cyc_t(); #1;
        checks++; if ({bus_we_o, bus_sel_o} !== 5'b1_0011 || bus_addr_o !== 32'h300 || bus_data_o !== 32'hCAFE)
            $display("FAIL tmo_bus got=%b/%h/%h exp=10011/00000300/0000cafe", {bus_we_o, bus_sel_o}, bus_addr_o, bus_data_o); else passed++;
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus_err_o === 1'b1) begin
                found = 1;
                checks++; if (mem_stallreq_o !== 1'b0 || mem_data_o !== 32'h0) $display("FAIL tmo_err_cycle got=%b/%h exp=0/0", mem_stallreq_o, mem_data_o); else passed++;
            end else if (bus_cyc_o === 1'b1 && mem_stallreq_o === 1'b1) begin
                waits++;
            end
            cyc_t();
        end
        mem_ce_i = 1'b0; mem_we_i = 1'b0; #1;
        checks++; if (!found) $display("FAIL tmo_seen got=0 exp=1"); else passed++;
        checks++; if (waits != 15) $display("FAIL tmo_waits got=%0d exp=15", waits); else passed++;
        checks++; if (bus_cyc_o !== 1'b0 || bus_err_o !== 1'b0) $display("FAIL tmo_after got=%b%b exp=00", bus_cyc_o, bus_err_o); else passed++;
        $display("txn timeout store=00000300 waits=%0d", waits);
    endtask

    task automatic test_rst_mid();
        cyc_t(); mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h400; mem_data_i = 32'h5555_AAAA;
        cyc_t(); #1;
        checks++; if (bus_cyc_o !== 1'b1) $display("FAIL rst_busy got=%b exp=1", bus_cyc_o); else passed++;
        rst = 1'b1; #1;
        checks++; if (mem_stallreq_o !== 1'b0) $display("FAIL rst_stall_forced got=%b exp=0", mem_stallreq_o); else passed++;
        cyc_t(); #1;
        checks++; if ({bus_cyc_o, bus_we_o, bus_sel_o, bus_err_o} !== 7'h0 || {bus_addr_o, bus_data_o} !== 64'h0 || {if_data_o, mem_data_o} !== 64'h0)
            $display("FAIL rst_outputs got=%b/%h/%h exp=0", {bus_cyc_o, bus_we_o, bus_sel_o, bus_err_o}, {bus_addr_o, bus_data_o}, {if_data_o, mem_data_o}); else passed++;
        rst = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h404;
        cyc_t(); #1;
        checks++; if (bus_cyc_o !== 1'b1 || bus_addr_o !== 32'h404 || bus_we_o !== 1'b0) $display("FAIL rst_rerequest got=%b/%h/%b exp=1/00000404/0", bus_cyc_o, bus_addr_o, bus_we_o); else passed++;
        bus_ack_i = 1'b1; bus_data_i = 32'h7777_8888; #1;
        checks++; if (mem_data_o !== 32'h7777_8888 || mem_stallreq_o !== 1'b0) $display("FAIL rst_reload got=%h/%b exp=77778888/0", mem_data_o, mem_stallreq_o); else passed++;
        cyc_t(); bus_ack_i = 1'b0; mem_ce_i = 1'b0; #1;
        $display("txn reset_mid then load=00000404");
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int          pick, wait_n, delay;
            bit          pend_if, pend_mem, in_bus, after_ack;
            logic [31:0] a_if, a_mem, wd, rd;
            logic [3:0]  sel;
            logic        we;
            int          exp_q[$];
            pick     = int'($urandom_range(2, 0));
            pend_if  = (pick != 1);
            pend_mem = (pick != 0);
            a_if  = $urandom & 32'hFFFF_FFFC;
            a_mem = $urandom & 32'hFFFF_FFFC;
            wd    = $urandom;
            sel   = 4'($urandom_range(15, 1));
            we    = 1'($urandom_range(1, 0));
            exp_q = {};
            // Expected bus order: the data port always goes first.
            if (pend_mem) exp_q.push_back(1);
            if (pend_if)  exp_q.push_back(0);
            cyc_t();
            if_ce_i = pend_if; if_addr_i = a_if;
            mem_ce_i = pend_mem; mem_we_i = we; mem_sel_i = sel; mem_addr_i = a_mem; mem_data_i = wd;
            in_bus = 0; after_ack = 0; wait_n = 0; delay = 0;
            for (int c = 0; c < 60 && (pend_if || pend_mem); c++) begin
                #1;
                checks++; if (if_stallreq_o !== pend_if || mem_stallreq_o !== pend_mem)
                    $display("FAIL rand_stallreq t=%0d got=%b%b exp=%b%b", t, if_stallreq_o, mem_stallreq_o, pend_if, pend_mem); else passed++;
                if (after_ack) begin
                    after_ack = 0;
                    checks++; if (bus_cyc_o !== 1'b0) $display("FAIL rand_gap t=%0d got=%b exp=0", t, bus_cyc_o); else passed++;
                end else if (bus_cyc_o === 1'b1) begin
                    if (!in_bus) begin
                        in_bus = 1; wait_n = 0; delay = int'($urandom_range(3, 0));
                        checks++;
                        if (exp_q.size() == 0) $display("FAIL rand_unexpected t=%0d got=cyc exp=none", t);
                        else if (exp_q[0] == 1 && (bus_addr_o !== a_mem || bus_we_o !== we || bus_sel_o !== sel || bus_data_o !== wd))
                            $display("FAIL rand_mem_bus t=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", t, bus_addr_o, bus_we_o, bus_sel_o, bus_data_o, a_mem, we, sel, wd);
                        else if (exp_q[0] == 0 && (bus_addr_o !== a_if || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF))
                            $display("FAIL rand_if_bus t=%0d got=%h/%b/%h exp=%h/0/f", t, bus_addr_o, bus_we_o, bus_sel_o, a_if);
                        else passed++;
                    end
                    if (wait_n == delay && exp_q.size() != 0) begin
                        rd = $urandom; bus_ack_i = 1'b1; bus_data_i = rd; #1;
                        checks++;
                        if (exp_q[0] == 1) begin
                            if (mem_data_o !== rd || mem_stallreq_o !== 1'b0) $display("FAIL rand_mem_ack t=%0d got=%h/%b exp=%h/0", t, mem_data_o, mem_stallreq_o, rd); else passed++;
                            pend_mem = 0;
                        end else begin
                            if (if_data_o !== rd || if_stallreq_o !== 1'b0) $display("FAIL rand_if_ack t=%0d got=%h/%b exp=%h/0", t, if_data_o, if_stallreq_o, rd); else passed++;
                            pend_if = 0;
                        end
                        void'(exp_q.pop_front());
                        in_bus = 0; after_ack = 1;
                    end else begin
                        wait_n++;
                    end
                end
                cyc_t();
                bus_ack_i = 1'b0; bus_data_i = $urandom;
                if_ce_i = pend_if; mem_ce_i = pend_mem;
            end
            #1;
            checks++; if (pend_if || pend_mem) $display("FAIL rand_done t=%0d got=pending%b%b exp=00", t, pend_if, pend_mem); else passed++;
            checks++; if (bus_cyc_o !== 1'b0) $display("FAIL rand_final_gap t=%0d got=%b exp=0", t, bus_cyc_o); else passed++;
            $display("txn rand %0d ports=%0d if=%h mem=%h we=%b sel=%h", t, pick, a_if, a_mem, we, sel);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_fetch();
        test_contention();
        test_hold();
        test_flush();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
